ms_ff_shift_ctrl: RTL
=====================

Name: ms_ff_shift_ctrl

Overview:
- Sequencer for a bit-serial chain of master-slave D flip-flops.
- Accepts a parallel word over a valid/ready handshake, then drives it one bit per clock onto the chain's D input with a shift enable. Signals completion with a one-cycle pulse.
- Sits between a parallel producer and the flip-flop shift chain. Supports stall and flush.

Parameters:
- WIDTH, 8, data word width in bits (≥2).
- LSB_FIRST, 1, 1 = bit 0 shifted first, 0 = bit WIDTH-1 shifted first.
- CNT_W, $clog2(WIDTH+2), width of bit counter (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk edge).
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  controller can accept a word this cycle.
- in_data  input  WIDTH  parallel word.
- stall  input  1  freeze shifting while high.
- flush  input  1  abort current word, return to IDLE.
- ff_d  output  1  serial bit to chain D input.
- ff_en  output  1  chain shift enable; chain captures ff_d when high.
- busy  output  1  high in SHIFT/PAR/DONE states.
- done  output  1  one-cycle pulse after the last bit.
- bit_cnt  output  CNT_W  number of bits already shifted for the current word.

Behaviour:
- Reset, when reset=0 at a clk edge:
  - state=IDLE, shift register=0, bit_cnt=0.
  - Outputs: in_ready=0 during reset, then 1 in IDLE; ff_d=0, ff_en=0, busy=0, done=0.
  - Reset mid-word discards the word. No done pulse is issued.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, load in_data into shift register, set bit_cnt=0, go to SHIFT.
  - SHIFT:
    - ff_en=1 and ff_d=current bit (LSB or MSB per LSB_FIRST) each non-stalled cycle; shift register advances and bit_cnt increments.
    - When bit_cnt reaches WIDTH-1 and the cycle is not stalled, go to DONE (or to PAR when the option is enabled).
  - DONE: done=1 for exactly one cycle, ff_en=0, in_ready=0, then go to IDLE.
- Latency:
  - Word accepted at edge N; first bit is driven in cycle N+1; last bit in cycle N+WIDTH; done in cycle N+WIDTH+1.
  - in_ready reasserts in cycle N+WIDTH+2.
  - Back-to-back throughput is one word per WIDTH+2 cycles.
- in_ready=0 in every state except IDLE. in_valid outside IDLE is ignored; the producer must hold the word.
- stall:
  - In SHIFT, ff_en=0, ff_d holds its last value, bit_cnt and shift register hold.
  - Has no effect in IDLE or DONE; done is never delayed.
- flush:
  - Applies in any non-IDLE state: next state=IDLE, bit_cnt=0, ff_en=0 from the next cycle, no done pulse.
  - In IDLE, flush blocks acceptance that cycle (in_ready=0).
  - flush has priority over stall and over shift completion.
- ff_d=0 and ff_en=0 whenever the state is not SHIFT or PAR.
- bit_cnt saturates at WIDTH (WIDTH+1 with the option) in DONE and clears on entering IDLE.

Optional Feature:
- SHIFT_PARITY_EN defined:
  - After the last data bit, state PAR drives one extra bit: ff_d = even parity (XOR of the captured word), ff_en=1. PAR honours stall and flush.
  - done then appears in cycle N+WIDTH+2, and bit_cnt reaches WIDTH+1.
- SHIFT_PARITY_EN undefined: PAR state and parity logic are absent; SHIFT goes directly to DONE.

Test Plan:
1. Run with WIDTH=8, LSB_FIRST=1; in_valid with in_data=8'hA5 accepted at edge 0 -> ff_d=1,0,1,0,0,1,0,1 with ff_en=1 in cycles 1–8; done=1 in cycle 9 only; in_ready=1 in cycle 10.
2. Run with LSB_FIRST=0 and in_data=8'hC3 -> ff_d=1,1,0,0,0,0,1,1; bit_cnt=0..7 during shift, 8 in DONE.
3. Load 8'hFF and assert stall in cycles 3–5 -> ff_en=0 and bit_cnt=2 held in those cycles; done moves to cycle 12; exactly 8 ff_en pulses in total.
4. Load 8'h0F and assert flush in cycle 4 -> ff_en=0 from cycle 5, busy=0, in_ready=1 in cycle 5, no done pulse; a following word 8'h01 shifts correctly.
5. Drive reset=0 for one edge at cycle 6 of a word -> all outputs at reset values from the next cycle; no done; asserting in_valid during reset is not accepted.
6. With SHIFT_PARITY_EN defined, load 8'h07 -> 8 data bits, then ff_d=1 with ff_en=1 in cycle 9, done in cycle 10. Repeat with 8'h03 -> parity bit 0.

Source files
------------

// File: rtl/ms_ff_shift_ctrl_if.sv
// Parallel-word handshake between a producer and the shift-chain sequencer.
// The producer drives the master modport and the sequencer uses the slave modport.
interface ms_ff_shift_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/ms_ff_shift_ctrl.sv
// Sequencer that shifts a parallel word one bit per clock into a master-slave DFF chain.
// Defining SHIFT_PARITY_EN appends an even-parity bit (state PAR) after the data bits.
module ms_ff_shift_ctrl #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          LSB_FIRST = 1'b1,
  parameter int unsigned CNT_W     = $clog2(WIDTH + 2)
) (
  input  logic              clk,
  input  logic              reset,
  ms_ff_shift_ctrl_if.slave in_bus,
  input  logic              stall,
  input  logic              flush,
  output logic              ff_d,
  output logic              ff_en,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_cnt
);
  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;
`ifdef SHIFT_PARITY_EN
  localparam logic [1:0] StPar   = 2'd3;
`endif
  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ff_d_q;
  logic             accept;
  logic             shifting;
  logic             cur_bit;
`ifdef SHIFT_PARITY_EN
  logic             par_q, par_d;
`endif

  assign in_bus.in_ready = reset && (state_q == StIdle) && !flush;
  assign accept          = in_bus.in_ready && in_bus.in_valid;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef SHIFT_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          shreg_d = in_bus.in_data;
          cnt_d   = '0;
          state_d = StShift;
`ifdef SHIFT_PARITY_EN
          par_d   = ^in_bus.in_data;
`endif
        end
      end
      StShift: begin
        if (!stall) begin
          shreg_d = LSB_FIRST ? (shreg_q >> 1) : (shreg_q << 1);
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LastIdx) begin
`ifdef SHIFT_PARITY_EN
            state_d = StPar;
`else
            state_d = StDone;
`endif
          end
        end
      end
`ifdef SHIFT_PARITY_EN
      StPar: begin
        if (!stall) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = StDone;
        end
      end
`endif
      StDone: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
    // Flush wins over stall and over completion of the last bit.
    if (flush && (state_q != StIdle)) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  always_comb begin
    cur_bit  = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
    shifting = (state_q == StShift);
`ifdef SHIFT_PARITY_EN
    if (state_q == StPar) begin
      cur_bit  = par_q;
      shifting = 1'b1;
    end
`endif
    ff_en   = shifting && !stall;
    // A stalled cycle repeats whatever was last presented on ff_d.
    ff_d    = shifting ? (stall ? ff_d_q : cur_bit) : 1'b0;
    busy    = (state_q != StIdle);
    done    = (state_q == StDone) && !flush;
    bit_cnt = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
      ff_d_q  <= 1'b0;
`ifdef SHIFT_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      ff_d_q  <= ff_d;
`ifdef SHIFT_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end
endmodule
